// File: rtl/rf_wgt_pp.sv
// rf_wgt_pp: ping-pong weight register file. A shadow bank of K signed
// weights loads serially over valid/ready while the active bank feeds
// the PE array; a swap publishes the shadow bank to the active bank.
// Optional macro RF_WGT_ZMASK_EN enables the per-tap zero mask.
// Ports:
//   clk, rstn            clock, async active-low reset
//   wgt_in/_valid/_ready serial weight load handshake
//   swap, flush          publish request, shadow discard
//   swap_ack             one-cycle pulse when a swap is taken
//   shadow_full          shadow bank holds K words
//   act_valid            active bank holds a published row
//   wgt_act              active taps, tap i at [i*DW +: DW]
//   wgt_zmask            per-tap zero flag of the active bank
module rf_wgt_pp #(
  parameter int DW = 8,
  parameter int K  = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [DW-1:0]   wgt_in,
  input  logic            wgt_valid,
  output logic            wgt_ready,
  input  logic            swap,
  input  logic            flush,
  output logic            swap_ack,
  output logic            shadow_full,
  output logic            act_valid,
  output logic [DW*K-1:0] wgt_act,
  output logic [K-1:0]    wgt_zmask
);

  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LP_LAST = CW'(K-1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_FULL
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [K-1:0][DW-1:0] r_sh;
  logic [K-1:0][DW-1:0] r_act;
  logic                 r_act_valid;
  logic                 r_swap_ack;
  logic                 r_full;

  logic w_accept;
  logic w_swap_take;

  assign wgt_ready   = (r_state != S_FULL);
  assign w_accept    = wgt_valid & wgt_ready;
  assign w_swap_take = swap & (r_state == S_FULL) & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_EMPTY;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_act       <= '0;
      r_act_valid <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      // flush outranks swap and accept; the incoming word is dropped
      if (flush) begin
        r_state <= S_EMPTY;
        r_cnt   <= '0;
        r_full  <= 1'b0;
      end else if (w_swap_take) begin
        r_act       <= r_sh;
        r_act_valid <= 1'b1;
        r_swap_ack  <= 1'b1;
        r_state     <= S_EMPTY;
        r_cnt       <= '0;
        r_full      <= 1'b0;
      end else if (w_accept) begin
        for (int i = K-1; i > 0; i--) begin
          r_sh[i] <= r_sh[i-1];
        end
        r_sh[0] <= wgt_in;
        if (r_cnt == LP_LAST) begin
          r_state <= S_FULL;
          r_cnt   <= '0;
          r_full  <= 1'b1;
        end else begin
          r_state <= S_FILL;
          r_cnt   <= r_cnt + CW'(1);
        end
      end
    end
  end

`ifdef RF_WGT_ZMASK_EN
  logic [K-1:0] r_zmask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_zmask <= '0;
    end else if (w_swap_take) begin
      for (int i = 0; i < K; i++) begin
        r_zmask[i] <= (r_sh[i] == '0);
      end
    end
  end

  assign wgt_zmask = r_zmask;
`else
  assign wgt_zmask = '0;
`endif

  assign wgt_act     = r_act;
  assign act_valid   = r_act_valid;
  assign swap_ack    = r_swap_ack;
  assign shadow_full = r_full;

endmodule

// File: tb/tb_rf_wgt_pp.sv
// tb_rf_wgt_pp: random plus directed stimulus for rf_wgt_pp,
// compared each cycle against a list-based reference model.
module tb_rf_wgt_pp;

  localparam int DW = 8;
  localparam int K  = 3;

  logic            clk;
  logic            rstn;
  logic [DW-1:0]   wgt_in;
  logic            wgt_valid;
  logic            wgt_ready;
  logic            swap;
  logic            flush;
  logic            swap_ack;
  logic            shadow_full;
  logic            act_valid;
  logic [DW*K-1:0] wgt_act;
  logic [K-1:0]    wgt_zmask;

  int n_chk;
  int n_err;

  // model: words currently held (0..K) and the last K words loaded
  int            m_n;
  logic [DW-1:0] m_sh  [K];
  logic [DW-1:0] m_act [K];
  logic          m_av;
  logic          m_ack;
  logic [K-1:0]  m_zm;

  rf_wgt_pp #(.DW(DW), .K(K)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .wgt_in     (wgt_in),
    .wgt_valid  (wgt_valid),
    .wgt_ready  (wgt_ready),
    .swap       (swap),
    .flush      (flush),
    .swap_ack   (swap_ack),
    .shadow_full(shadow_full),
    .act_valid  (act_valid),
    .wgt_act    (wgt_act),
    .wgt_zmask  (wgt_zmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_n   = 0;
    m_av  = 1'b0;
    m_ack = 1'b0;
    m_zm  = '0;
    for (int i = 0; i < K; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
  endtask

  task automatic m_step(input logic v, input logic [DW-1:0] d,
                        input logic s, input logic f);
    m_ack = 1'b0;
    if (f) begin
      m_n = 0;
    end else if (s && m_n == K) begin
      for (int i = 0; i < K; i++) begin
        m_act[i] = m_sh[i];
      end
`ifdef RF_WGT_ZMASK_EN
      for (int i = 0; i < K; i++) begin
        m_zm[i] = (m_sh[i] == '0);
      end
`endif
      m_av  = 1'b1;
      m_ack = 1'b1;
      m_n   = 0;
    end else if (v && m_n != K) begin
      for (int i = K-1; i > 0; i--) begin
        m_sh[i] = m_sh[i-1];
      end
      m_sh[0] = d;
      m_n++;
    end
  endtask

  function automatic logic [DW*K-1:0] m_act_flat();
    logic [DW*K-1:0] r;
    r = '0;
    for (int i = 0; i < K; i++) begin
      r[i*DW +: DW] = m_act[i];
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 64'(wgt_ready),   64'(m_n != K));
    chk({tag, ".full"},  64'(shadow_full), 64'(m_n == K));
    chk({tag, ".av"},    64'(act_valid),   64'(m_av));
    chk({tag, ".ack"},   64'(swap_ack),    64'(m_ack));
    chk({tag, ".act"},   64'(wgt_act),     64'(m_act_flat()));
    chk({tag, ".zm"},    64'(wgt_zmask),   64'(m_zm));
  endtask

  // inputs change at negedge; DUT and model advance at posedge
  task automatic step(input string tag, input logic v,
                      input logic [DW-1:0] d,
                      input logic s, input logic f);
    wgt_valid = v;
    wgt_in    = d;
    swap      = s;
    flush     = f;
    @(posedge clk);
    m_step(v, d, s, f);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic load3(input string tag, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] c);
    step(tag, 1'b1, a, 1'b0, 1'b0);
    step(tag, 1'b1, b, 1'b0, 1'b0);
    step(tag, 1'b1, c, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rstn      = 1'b0;
    wgt_in    = '0;
    wgt_valid = 1'b0;
    swap      = 1'b0;
    flush     = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("rst");
    rstn = 1'b1;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // row 5,-3,7 then swap on the following cycle
    load3("row1", 8'd5, 8'hFD, 8'd7);
    chk("row1.full", 64'(shadow_full), 64'd1);
    step("row1s", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("row1.ackd", 64'(swap_ack), 64'd1);
    chk("row1.actd", 64'(wgt_act), 64'h05FD07);

    // full bank refuses a word; swap with the last accept is ignored
    load3("f", 8'd1, 8'd2, 8'd3);
    step("fv", 1'b1, 8'd9, 1'b0, 1'b0);
    step("fs", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("f.actd", 64'(wgt_act), 64'h010203);
    step("e1", 1'b1, 8'd11, 1'b0, 1'b0);
    step("e2", 1'b1, 8'd12, 1'b0, 1'b0);
    step("e3", 1'b1, 8'd13, 1'b1, 1'b0);
    chk("early.ack", 64'(swap_ack), 64'd0);
    step("e4", 1'b0, 8'h00, 1'b1, 1'b0);
    step("e5", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("hold.ack", 64'(swap_ack), 64'd0);

    // flush beats accept and swap
    step("fl1", 1'b1, 8'd1, 1'b0, 1'b0);
    step("fl2", 1'b1, 8'd2, 1'b0, 1'b0);
    step("fl3", 1'b1, 8'd4, 1'b1, 1'b1);
    load3("rl", 8'd4, 8'd0, 8'd6);
    step("rls", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rl.actd", 64'(wgt_act), 64'h040006);
`ifdef RF_WGT_ZMASK_EN
    chk("rl.zmd", 64'(wgt_zmask), 64'b010);
`else
    chk("rl.zmd", 64'(wgt_zmask), 64'b000);
`endif

    // next row loads behind the active one
    load3("r2", 8'd10, 8'd20, 8'd30);
    chk("r2.old", 64'(wgt_act), 64'h040006);
    step("r2s", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("r2.new", 64'(wgt_act), 64'h0A141E);

    // async reset mid-load
    step("m1", 1'b1, 8'd77, 1'b0, 1'b0);
    step("m2", 1'b1, 8'd88, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    m_reset();
    check_all("arst");
    @(negedge clk);
    rstn = 1'b1;
    load3("pr", 8'd21, 8'd22, 8'd23);
    step("prs", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pr.actd", 64'(wgt_act), 64'h151617);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      step("rnd", ($urandom_range(0, 3) != 0), d,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
